mdu_ctrl: RTL and testbench

- Multiply/divide controller for the E stage of the 5-stage pipeline; owns the HI/LO registers.
- Sequences mult, multu, div, divu over a fixed multi-cycle latency.
- Executes mthi/mtlo as single-cycle writes.
- Raises a stall request that the hazard unit ORs into its D-stage Stall, so no later multiply/divide-class instruction leaves D while an operation is pending.

---
 rtl/mdu_ctrl_pkg.sv | 27 ++
 rtl/mdu_arith.sv | 72 +++++++
 rtl/mdu_ctrl.sv | 102 ++++++++++
 tb/tb_mdu_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the multiply/divide unit, decoder and hazard unit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mdu_ctrl_pkg;

    // MDOp encodings driven by the decoder into the E stage
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_t;

    // Controller states
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    // Busy counter width; holds the longer of the two operation latencies
    localparam int MD_CNT_W = 4;

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing HI/LO results for one op.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the controller decides when results are captured.
module mdu_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] b_safe;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic        is_div;

    // Low 64 bits of the product of sign-extended operands equal the signed product
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Never divide by zero in hardware; the result is discarded in that case anyway
    assign b_safe = (B == 32'd0) ? 32'd1 : B;

    // Signed divide built on magnitudes so 0x80000000 / -1 simply wraps
    assign a_mag = A[31] ? (~A + 32'd1) : A;
    assign b_mag = b_safe[31] ? (~b_safe + 32'd1) : b_safe;
    assign q_mag = a_mag / b_mag;
    assign r_mag = a_mag % b_mag;
    assign q_s   = (A[31] ^ b_safe[31]) ? (~q_mag + 32'd1) : q_mag;
    assign r_s   = A[31] ? (~r_mag + 32'd1) : r_mag;

    assign is_div   = (MDOp == MD_DIV) || (MDOp == MD_DIVU);
    assign div_zero = is_div && (B == 32'd0);

    // Select the HI/LO pair for the requested operation
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (MDOp)
            MD_MULT: begin
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            MD_MULTU: begin
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            MD_DIV: begin
                res_hi = r_s;
                res_lo = q_s;
            end
            MD_DIVU: begin
                res_hi = A % b_safe;
                res_lo = A / b_safe;
            end
            default: begin
                res_hi = 32'd0;
                res_lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller owning HI/LO; sequences mult/div and mthi/mtlo.
// Latency: Busy for MULT_CYCLES/DIV_CYCLES after Start, HI/LO new the cycle after; mthi/mtlo 1 edge.
// Backpressure: Stall_MD holds a D-stage MD-class instruction while an op is in E or busy.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MD_D,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Stall_MD
);

    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

    md_state_t           state;
    logic [MD_CNT_W-1:0] count;
    logic [31:0]         pend_hi;
    logic [31:0]         pend_lo;
    logic                pend_skip;
    logic [31:0]         res_hi;
    logic [31:0]         res_lo;
    logic                div_zero;
    logic                start_op;
    logic                is_div;

    mdu_arith u_arith (
        .MDOp     (MDOp),
        .A        (A),
        .B        (B),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    // Start only counts for real multiply/divide opcodes
    assign start_op = Start && ((MDOp == MD_MULT) || (MDOp == MD_MULTU) ||
                                (MDOp == MD_DIV)  || (MDOp == MD_DIVU));
    assign is_div   = (MDOp == MD_DIV) || (MDOp == MD_DIVU);

    // Covers the cycle the op sits in E as well as every busy cycle
    assign Stall_MD = MD_D && (Start || Busy);

    // Controller FSM: capture result at start, count down, commit to HI/LO at the last busy edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            Busy      <= 1'b0;
            HI        <= 32'd0;
            LO        <= 32'd0;
            pend_hi   <= 32'd0;
            pend_lo   <= 32'd0;
            pend_skip <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_op) begin
                        pend_hi   <= res_hi;
                        pend_lo   <= res_lo;
                        pend_skip <= div_zero;
                        count     <= is_div ? DIV_LOAD : MULT_LOAD;
                        Busy      <= 1'b1;
                        state     <= BUSY;
                    end else if (MDOp == MD_MTHI) begin
                        HI <= A;
                    end else if (MDOp == MD_MTLO) begin
                        LO <= A;
                    end
                end
                BUSY: begin
                    // New starts and moves are dropped here; the hazard unit never issues them
                    count <= count - 1'b1;
                    if (count == MD_CNT_W'(1)) begin
                        if (!pend_skip) begin
                            HI <= pend_hi;
                            LO <= pend_lo;
                        end
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: vector table for arithmetic plus hand sequences for timing corners.
// Latency: n/a.
// Backpressure: n/a.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        MD_D;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Stall_MD;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
        string       name;
    } vec_t;

    vec_t vecs [10];

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .Start    (Start),
        .MDOp     (MDOp),
        .A        (A),
        .B        (B),
        .MD_D     (MD_D),
        .Busy     (Busy),
        .HI       (HI),
        .LO       (LO),
        .Stall_MD (Stall_MD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
    endtask

    // Issue one mult/div, count busy cycles, check HI/LO hold then commit
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int cyc, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic [31:0] phi, input logic [31:0] plo, input string nm);
        int n;
        Start = 1'b1; MDOp = op; A = a; B = b;
        step();
        Start = 1'b0; MDOp = MD_NONE; A = 32'd0; B = 32'd0;
        n = 0;
        while (Busy === 1'b1 && n < 64) begin
            n++;
            if (n == cyc) begin
                chk({nm, " hold_hi"}, HI, phi);
                chk({nm, " hold_lo"}, LO, plo);
            end
            step();
        end
        chk({nm, " busy_cycles"}, 32'(n), 32'(cyc));
        chk({nm, " hi"}, HI, ehi);
        chk({nm, " lo"}, LO, elo);
    endtask

    initial begin
        logic [31:0] phi;
        logic [31:0] plo;
        int n;

        vecs[0] = '{MD_MULT,  32'hFFFFFFFE, 32'h00000003,  5, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg"};
        vecs[1] = '{MD_MULTU, 32'hFFFFFFFE, 32'h00000003,  5, 32'h00000002, 32'hFFFFFFFA, "multu"};
        vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg"};
        vecs[3] = '{MD_DIVU,  32'h00000007, 32'h00000002, 10, 32'h00000001, 32'h00000003, "divu"};
        vecs[4] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, "div_ovf"};
        vecs[5] = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, "div_negdiv"};
        vecs[6] = '{MD_MULT,  32'h80000000, 32'h80000000,  5, 32'h40000000, 32'h00000000, "mult_min"};
        vecs[7] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,  5, 32'hFFFFFFFE, 32'h00000001, "multu_max"};
        vecs[8] = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 10, 32'h0000000F, 32'h0FFFFFFF, "divu_big"};
        vecs[9] = '{MD_DIV,   32'h00000005, 32'h00000000, 10, 32'h0000000F, 32'h0FFFFFFF, "div_zero"};

        reset = 1'b1; Start = 1'b0; MDOp = MD_NONE; A = 32'd0; B = 32'd0; MD_D = 1'b0;
        step();
        step();
        reset = 1'b0;
        #1;
        chk("reset busy", 32'(Busy), 32'd0);
        chk("reset hi", HI, 32'd0);
        chk("reset lo", LO, 32'd0);
        MD_D = 1'b1;
        #1;
        chk("idle stall", 32'(Stall_MD), 32'd0);
        MD_D = 1'b0;

        // Vector table
        phi = 32'd0;
        plo = 32'd0;
        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cyc, vecs[i].hi, vecs[i].lo,
                  phi, plo, vecs[i].name);
            phi = vecs[i].hi;
            plo = vecs[i].lo;
        end

        // Start with a non-arithmetic opcode is no start
        Start = 1'b1; MDOp = MD_RSVD; A = 32'h11111111; B = 32'h2;
        step();
        Start = 1'b0; MDOp = MD_NONE;
        chk("rsvd busy", 32'(Busy), 32'd0);
        chk("rsvd hi", HI, 32'h0000000F);
        chk("rsvd lo", LO, 32'h0FFFFFFF);

        // mthi then mtlo back to back
        MDOp = MD_MTHI; A = 32'h12345678;
        step();
        chk("mthi hi", HI, 32'h12345678);
        chk("mthi lo_kept", LO, 32'h0FFFFFFF);
        chk("mthi busy", 32'(Busy), 32'd0);
        MDOp = MD_MTLO; A = 32'h9ABCDEF0;
        step();
        chk("mtlo lo", LO, 32'h9ABCDEF0);
        chk("mtlo hi_kept", HI, 32'h12345678);
        chk("mtlo busy", 32'(Busy), 32'd0);
        MDOp = MD_NONE; A = 32'd0;
        do_op(MD_DIVU, 32'h00000009, 32'h00000000, 10, 32'h12345678, 32'h9ABCDEF0,
              32'h12345678, 32'h9ABCDEF0, "divu_zero");

        // Stall held for the E cycle plus all ten busy cycles
        MD_D = 1'b1; Start = 1'b1; MDOp = MD_DIV; A = 32'd100; B = 32'd7;
        #1;
        chk("stall e_cycle", 32'(Stall_MD), 32'd1);
        step();
        Start = 1'b0; MDOp = MD_NONE; A = 32'd0; B = 32'd0;
        for (int c = 1; c <= 10; c++) begin
            #1;
            chk($sformatf("stall busy_%0d", c), 32'(Stall_MD), 32'd1);
            step();
        end
        #1;
        chk("stall released", 32'(Stall_MD), 32'd0);
        chk("stall div lo", LO, 32'd14);
        chk("stall div hi", HI, 32'd2);

        // No D-stage MD instruction: never stall
        MD_D = 1'b0; Start = 1'b1; MDOp = MD_MULT; A = 32'd3; B = 32'd3;
        #1;
        n = 0;
        if (Stall_MD !== 1'b0) n++;
        step();
        Start = 1'b0; MDOp = MD_NONE;
        for (int c = 0; c < 6; c++) begin
            if (Stall_MD !== 1'b0) n++;
            step();
        end
        chk("no_md_d stall_cycles", 32'(n), 32'd0);
        chk("no_md_d lo", LO, 32'd9);

        // Reset at busy cycle 3 aborts the op with no later commit
        Start = 1'b1; MDOp = MD_MULT; A = 32'd5; B = 32'd6;
        step();
        Start = 1'b0; MDOp = MD_NONE;
        step();
        step();
        chk("abort busy_before", 32'(Busy), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort busy", 32'(Busy), 32'd0);
        chk("abort hi", HI, 32'd0);
        chk("abort lo", LO, 32'd0);
        n = 0;
        for (int c = 0; c < 8; c++) begin
            if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) n++;
            step();
        end
        chk("abort no_commit", 32'(n), 32'd0);
        do_op(MD_MULT, 32'd7, 32'd8, 5, 32'd0, 32'd56, 32'd0, 32'd0, "after_abort");

        // Start during BUSY is ignored: original result lands on schedule
        Start = 1'b1; MDOp = MD_MULT; A = 32'd3; B = 32'd4;
        step();
        Start = 1'b0; MDOp = MD_NONE; A = 32'd0; B = 32'd0;
        n = 0;
        while (Busy === 1'b1 && n < 64) begin
            n++;
            if (n == 2) begin
                Start = 1'b1; MDOp = MD_DIV; A = 32'd100; B = 32'd5;
            end else begin
                Start = 1'b0; MDOp = MD_NONE; A = 32'd0; B = 32'd0;
            end
            step();
        end
        Start = 1'b0; MDOp = MD_NONE; A = 32'd0; B = 32'd0;
        chk("busy_start busy_cycles", 32'(n), 32'd5);
        chk("busy_start hi", HI, 32'd0);
        chk("busy_start lo", LO, 32'd12);
        step();
        chk("busy_start idle", 32'(Busy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
